// File: rtl/isp_spi_bridge.sv
// isp_spi_bridge: host byte-command interpreter driving a mode-0 SPI master on up to four chip selects.
module isp_spi_bridge #(
  parameter int CS_COUNT  = 1,
  parameter int DIV_RESET = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                spi_sclk,
  output logic [CS_COUNT-1:0] spi_csn,
  output logic                spi_mosi,
  input  logic                spi_miso,
  output logic                busy,
  output logic                err
);
  typedef enum logic [2:0] {S_IDLE, S_ARG, S_WDATA, S_SHIFT, S_RESP} state_t;
  localparam logic [7:0] CS_N = 8'(CS_COUNT);
  state_t              r_state;
  logic [7:0]          r_op, r_cnt, r_div, r_shift, r_cap, r_tick, r_tx_data;
  logic [2:0]          r_bits;
  logic [1:0]          r_sel;
  logic [CS_COUNT-1:0] r_csn;
  logic                r_sclk, r_tx_valid, r_rx_ready, r_busy, r_err;
  logic                w_rx_fire, w_start;
  logic [7:0]          w_byte;
  logic [CS_COUNT-1:0] w_cs_low;
  assign w_rx_fire = rx_valid & r_rx_ready;
  // every entry into SHIFT loads a byte and drops the selected CS
  assign w_start   = (w_rx_fire & (r_state == S_WDATA | (r_state == S_ARG & r_op == 8'hC2)))
                   | (r_state == S_RESP & tx_ready & r_cnt != 8'd0);
  assign w_byte    = r_state == S_WDATA ? rx_data : 8'hFF;
  assign w_cs_low  = ~(CS_COUNT'(1) << r_sel);
  assign rx_ready  = r_rx_ready;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign spi_sclk  = r_sclk;
  assign spi_csn   = r_csn;
  assign spi_mosi  = r_shift[7];
  assign busy      = r_busy;
  assign err       = r_err;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= 8'd0;
      r_cnt      <= 8'd0;
      r_div      <= 8'(DIV_RESET);
      r_shift    <= 8'd0;
      r_cap      <= 8'd0;
      r_tick     <= 8'd0;
      r_tx_data  <= 8'd0;
      r_bits     <= 3'd0;
      r_sel      <= 2'd0;
      r_csn      <= '1;
      r_sclk     <= 1'b0;
      r_tx_valid <= 1'b0;
      r_rx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_rx_fire) begin
          r_op <= rx_data;
          if (rx_data == 8'h80) begin
            r_csn <= '1;
            r_err <= 1'b0;
          end else if (rx_data == 8'h81 || rx_data == 8'h82 || rx_data == 8'hC2 || rx_data == 8'h84) begin
            r_state <= S_ARG;
            r_busy  <= 1'b1;
          end else r_err <= 1'b1;
        end
        S_ARG: if (w_rx_fire) begin
          r_cnt <= rx_data;
          if (r_op == 8'h81) begin
            if (rx_data < CS_N) begin
              r_sel <= rx_data[1:0];
              r_csn <= '1;
            end else r_err <= 1'b1;
          end
          if (r_op == 8'h84) r_div <= rx_data;
          r_state <= r_op == 8'h82 ? S_WDATA : S_IDLE;
          r_busy  <= r_op == 8'h82;
        end
        S_SHIFT: begin
          if (r_tick != r_div) r_tick <= r_tick + 8'd1;
          else begin
            r_tick <= 8'd0;
            r_sclk <= ~r_sclk;
            if (!r_sclk) r_cap <= {r_cap[6:0], spi_miso};
            else if (r_bits != 3'd7) begin
              r_bits  <= r_bits + 3'd1;
              r_shift <= {r_shift[6:0], 1'b0};
            end else if (r_op == 8'hC2) begin
              r_state    <= S_RESP;
              r_tx_data  <= r_cap;
              r_tx_valid <= 1'b1;
            end else if (r_cnt == 8'd0) begin
              r_state    <= S_IDLE;
              r_rx_ready <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_cnt      <= r_cnt - 8'd1;
              r_state    <= S_WDATA;
              r_rx_ready <= 1'b1;
            end
          end
        end
        S_RESP: if (tx_ready) begin
          r_tx_valid <= 1'b0;
          if (r_cnt == 8'd0) begin
            r_state    <= S_IDLE;
            r_rx_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else r_cnt <= r_cnt - 8'd1;
        end
        default: ;
      endcase
      if (w_start) begin
        r_state    <= S_SHIFT;
        r_shift    <= w_byte;
        r_csn      <= w_cs_low;
        r_tick     <= 8'd0;
        r_bits     <= 3'd0;
        r_sclk     <= 1'b0;
        r_rx_ready <= 1'b0;
        r_busy     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_isp_spi_bridge.sv
// tb_isp_spi_bridge: directed command sequences with MOSI/tx scoreboards against an SPI flash-like MISO stream.
module tb_isp_spi_bridge;
  logic       clk = 1'b0, reset = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready = 1'b1;
  logic       spi_sclk, spi_mosi, spi_miso, busy, err;
  logic [1:0] spi_csn;
  int         n_checks = 0, n_fail = 0;
  logic [7:0] exp_tx[$], exp_mosi[$];
  int         rises = 0, base = 0, mbits = 0, shift_clks = 0, rb;
  logic [31:0] stream = 32'd0;
  logic [7:0] msr = 8'd0;
  logic       cnt_en = 1'b0;

  isp_spi_bridge #(.CS_COUNT(2), .DIV_RESET(1)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .spi_sclk(spi_sclk),
    .spi_csn(spi_csn), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  assign rb = rises - base;
  assign spi_miso = (rb >= 0 && rb < 32) ? stream[31 - rb] : 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge spi_sclk or posedge reset)
    if (reset) mbits = 0;
    else begin
      rises++;
      msr = {msr[6:0], spi_mosi};
      mbits++;
      if (mbits == 8) begin
        mbits = 0;
        if (exp_mosi.size() == 0) chk("mosi_unexpected", {24'd0, msr}, 32'hFFFF_FFFF);
        else chk("mosi_byte", {24'd0, msr}, {24'd0, exp_mosi.pop_front()});
      end
    end

  always @(negedge clk)
    if (!reset && tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) chk("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
      else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
    end

  always @(negedge clk) if (cnt_en && busy && !rx_ready) shift_clks++;

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("rx_accept", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc, t;
    int rise_at[$];
    logic prev, ok;
    logic [7:0] d0;
    repeat (3) @(negedge clk);
    chk("rst_csn", {30'd0, spi_csn}, 32'd3);
    chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    // JEDEC ID read against a flash returning EF 40 17 after the 9F opcode byte
    base = rises;
    stream = 32'h00EF_4017;
    exp_mosi.push_back(8'h9F);
    repeat (3) exp_mosi.push_back(8'hFF);
    exp_tx.push_back(8'hEF); exp_tx.push_back(8'h40); exp_tx.push_back(8'h17);
    send(8'h81); send(8'h00); send(8'h82); send(8'h00); send(8'h9F);
    chk("jedec_cs_fall", {30'd0, spi_csn}, 32'd2);
    wait_idle();
    chk("jedec_cs_hold", {30'd0, spi_csn}, 32'd2);
    send(8'hC2); send(8'h02);
    wait_idle();
    chk("jedec_cs_after_read", {30'd0, spi_csn}, 32'd2);
    send(8'h80);
    chk("jedec_cs_raise", {30'd0, spi_csn}, 32'd3);
    // divider 3: half-period 4 clocks, 64 clocks per byte
    exp_mosi.push_back(8'hA5);
    send(8'h84); send(8'h03); send(8'h82); send(8'h00); send(8'hA5);
    cyc = 0; t = 0; prev = 1'b0;
    while (t < 1000) begin
      @(negedge clk);
      t++;
      if (!busy) break;
      if (!rx_ready) cyc++;
      if (spi_sclk && !prev) rise_at.push_back(cyc);
      prev = spi_sclk;
    end
    chk("div_byte_clocks", cyc, 64);
    chk("div_rise_count", rise_at.size(), 8);
    chk("div_first_rise", rise_at.size() > 1 ? rise_at[0] : -1, 5);
    chk("div_period", rise_at.size() > 1 ? rise_at[1] - rise_at[0] : -1, 8);
    chk("div_sclk_end", {31'd0, spi_sclk}, 32'd0);
    send(8'h84); send(8'h01);
    send(8'h80);
    // backpressure on the first of two read bytes
    base = rises;
    stream = 32'h3CA5_0000;
    exp_mosi.push_back(8'hFF); exp_mosi.push_back(8'hFF);
    exp_tx.push_back(8'h3C); exp_tx.push_back(8'hA5);
    tx_ready = 1'b0;
    send(8'hC2); send(8'h01);
    t = 0;
    while (!tx_valid && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("bp_tx_valid", {31'd0, tx_valid}, 32'd1);
    d0 = tx_data;
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      ok &= tx_valid && tx_data == d0 && !spi_sclk && !rx_ready && busy;
    end
    chk("bp_hold_stable", {31'd0, ok}, 32'd1);
    chk("bp_first_byte", {24'd0, d0}, 32'h3C);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_idle();
    // errors: bad select then bad opcode, 80 clears
    send(8'h81); send(8'h05);
    chk("err_bad_sel", {31'd0, err}, 32'd1);
    chk("err_cs_kept", {30'd0, spi_csn}, 32'd2);
    exp_mosi.push_back(8'h5A);
    send(8'h82); send(8'h00); send(8'h5A);
    wait_idle();
    chk("err_sel_unchanged", {30'd0, spi_csn}, 32'd2);
    send(8'h33);
    chk("err_bad_op", {31'd0, err}, 32'd1);
    chk("err_bad_op_idle", {31'd0, busy}, 32'd0);
    send(8'h80);
    chk("err_clear", {31'd0, err}, 32'd0);
    chk("err_cs_raise", {30'd0, spi_csn}, 32'd3);
    exp_mosi.push_back(8'hC3);
    send(8'h81); send(8'h01); send(8'h82); send(8'h00); send(8'hC3);
    wait_idle();
    chk("sel1_cs", {30'd0, spi_csn}, 32'd1);
    chk("sel1_err", {31'd0, err}, 32'd0);
    send(8'h80);
    // reset 20 clocks into a read byte: nothing returned
    send(8'hC2); send(8'h00);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_csn", {30'd0, spi_csn}, 32'd3);
    chk("mid_rst_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    exp_mosi.push_back(8'h81);
    send(8'h82); send(8'h00); send(8'h81);
    wait_idle();
    chk("post_rst_cs0", {30'd0, spi_csn}, 32'd2);
    send(8'h80);
    // 256-byte burst at DIV=1
    for (int i = 0; i < 256; i++) exp_mosi.push_back(8'(i * 7 + 3));
    shift_clks = 0;
    cnt_en = 1'b1;
    send(8'h82); send(8'hFF);
    for (int i = 0; i < 256; i++) send(8'(i * 7 + 3));
    wait_idle();
    cnt_en = 1'b0;
    chk("burst_shift_clks", shift_clks, 8192);
    chk("burst_rx_ready", {31'd0, rx_ready}, 32'd1);
    send(8'h80);
    repeat (5) @(negedge clk);
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("mosi_queue_drained", exp_mosi.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
